// File: rtl/aes_pkg.sv
// Shared AES MixColumns types, constants and GF(2^8) helper.
package aes_pkg;
   localparam logic [7:0] GF_POLY  = 8'h1B;
   localparam int         NUM_COLS = 4;

   typedef logic [127:0] state_t;
   typedef logic [31:0]  col_t;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} mix_state_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
   endfunction
endpackage

// File: rtl/mix_col_sub.sv
// Combinational single-column MixColumns unit (forward; inverse too when
// MIX_COL_INV_EN is defined).
module mix_col_sub
   import aes_pkg::*;
(
   input  col_t col_i,
`ifdef MIX_COL_INV_EN
   input  logic inv_i,
`endif
   output col_t col_o
);
   logic [7:0] b  [4];
   logic [7:0] x2 [4];
`ifdef MIX_COL_INV_EN
   logic [7:0] x4 [4];
   logic [7:0] x8 [4];
`endif

   always_comb begin
      col_o = '0;
      for (int i = 0; i < 4; i++) begin
         b[i]  = col_i[8*i +: 8];
         x2[i] = xtime(b[i]);
`ifdef MIX_COL_INV_EN
         x4[i] = xtime(x2[i]);
         x8[i] = xtime(x4[i]);
`endif
      end
      // Byte 3 is AES row 0, so the "next row" lives at the next-lower byte.
      for (int i = 0; i < 4; i++) begin
         col_o[8*i +: 8] = x2[i] ^ x2[(i+3)%4] ^ b[(i+3)%4] ^ b[(i+2)%4] ^ b[(i+1)%4];
`ifdef MIX_COL_INV_EN
         if (inv_i)
            col_o[8*i +: 8] = (x8[i] ^ x4[i] ^ x2[i])
                            ^ (x8[(i+3)%4] ^ x2[(i+3)%4] ^ b[(i+3)%4])
                            ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ b[(i+2)%4])
                            ^ (x8[(i+1)%4] ^ b[(i+1)%4]);
`endif
      end
   end
endmodule

// File: rtl/mix_col_seq.sv
// Time-multiplexed AES MixColumns: one column per clock, valid/ready on both
// sides. Define MIX_COL_INV_EN to add the inv_mode port and inverse transform.
module mix_col_seq #(
   parameter int NUM_COLS = 4,
   parameter int COL_W    = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NUM_COLS*COL_W-1:0] data_in,
`ifdef MIX_COL_INV_EN
   input  logic                      inv_mode,
`endif
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NUM_COLS*COL_W-1:0] data_out
);
   import aes_pkg::*;

   localparam logic [1:0] LAST_COL = 2'(NUM_COLS - 1);

   mix_state_t                fsm_q, fsm_d;
   logic [1:0]                cnt_q, cnt_d;
   logic [NUM_COLS*COL_W-1:0] st_q, st_d;
   logic [NUM_COLS*COL_W-1:0] dout_q, dout_d;
   logic                      in_ready_q, in_ready_d;
   logic                      out_valid_q, out_valid_d;
   logic [COL_W-1:0]          col_in, col_mix;
`ifdef MIX_COL_INV_EN
   logic                      inv_q, inv_d;
`endif

   assign col_in = st_q[int'(cnt_q)*COL_W +: COL_W];

   mix_col_sub u_col (
      .col_i (col_in),
`ifdef MIX_COL_INV_EN
      .inv_i (inv_q),
`endif
      .col_o (col_mix)
   );

   always_comb begin
      fsm_d       = fsm_q;
      cnt_d       = cnt_q;
      st_d        = st_q;
      dout_d      = dout_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
`ifdef MIX_COL_INV_EN
      inv_d       = inv_q;
`endif
      case (fsm_q)
         IDLE: begin
            if (in_valid) begin
               st_d       = data_in;
               cnt_d      = 2'd0;
               in_ready_d = 1'b0;
               fsm_d      = BUSY;
`ifdef MIX_COL_INV_EN
               inv_d      = inv_mode;
`endif
            end
         end
         BUSY: begin
            dout_d[int'(cnt_q)*COL_W +: COL_W] = col_mix;
            if (cnt_q == LAST_COL) begin
               cnt_d       = 2'd0;
               out_valid_d = 1'b1;
               fsm_d       = DONE;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         DONE: begin
            // No new accept in DONE: in_ready only rises with the handshake.
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               fsm_d       = IDLE;
            end
         end
         default: begin
            fsm_d       = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            cnt_d       = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q       <= IDLE;
         cnt_q       <= 2'd0;
         st_q        <= '0;
         dout_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef MIX_COL_INV_EN
         inv_q       <= 1'b0;
`endif
      end else begin
         fsm_q       <= fsm_d;
         cnt_q       <= cnt_d;
         st_q        <= st_d;
         dout_q      <= dout_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
`ifdef MIX_COL_INV_EN
         inv_q       <= inv_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign data_out  = dout_q;
endmodule

// File: doc/mix_col_seq.md
Name: mix_col_seq

Overview:
- Forward (encryption) AES MixColumns over a full 128-bit state.
- Time-multiplexed: one 32-bit column per clock through a single combinational column unit.
- Uses a valid/ready handshake on both sides.
- Sits in the encrypt round datapath between ShiftRows and AddRoundKey; undoes the decrypt-side inverse column substitution.

Parameters:
- NUM_COLS, 4, columns per state; fixed by AES, must stay 4.
- COL_W, 32, bits per column.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  state on data_in is valid
- in_ready  out  1  block can accept a state
- data_in  in  128  input state; column c = bits [32c+31:32c], byte i of a column = bits [8i+7:8i]
- out_valid  out  1  data_out holds a completed state
- out_ready  in  1  downstream accepts data_out
- data_out  out  128  mixed state, same layout as data_in
- inv_mode  in  1  present only with MIX_COL_INV_EN; selects the inverse transform

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- On reset: state=IDLE, in_ready=1, out_valid=0, data_out=0, column counter=0, internal state register=0.
- Column transform, per column, byte index i, arithmetic in GF(2^8) with polynomial 0x11B, xtime = shift left then conditional ^0x1B:
  - out[i] = 2*b[i] ^ 3*b[(i+3)%4] ^ b[(i+2)%4] ^ b[(i+1)%4]
  - Byte 3 is AES row 0, so column 0xDB135345 maps to 0x8E4DA1BC.
- FSM states IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid: capture data_in into the state register, cnt=0, go BUSY.
  - BUSY: in_ready=0. Each cycle column cnt goes through the column unit and is written into data_out column cnt; cnt++. After cnt==3 is written, go DONE.
  - DONE: out_valid=1 and data_out held stable until out_ready=1. Then out_valid=0 and return to IDLE. in_ready stays 0 in DONE, so there is no accept/complete overlap.
- Latency:
  - Input accepted on edge T.
  - Columns written on edges T+1..T+4.
  - out_valid=1 from T+4 until the handshake completes.
  - Throughput: one state per 6 cycles when out_ready=1 is held high.
- in_valid while BUSY or DONE is ignored. The upstream must hold the transfer until in_ready.
- data_in changes after acceptance have no effect.
- out_ready while not DONE is ignored.
- data_out keeps the last result after the handshake until overwritten by the next BUSY sequence.
- rst asserted in any state: next edge forces the reset values; any in-flight state is discarded with no partial output.
- cnt wraps only through the FSM and never exceeds 3.

Optional Feature:
- Macro: MIX_COL_INV_EN.
- When defined:
  - inv_mode port exists and is sampled with data_in at acceptance.
  - If inv_mode=1, each column uses out[i] = 14*b[i] ^ 11*b[(i+3)%4] ^ 13*b[(i+2)%4] ^ 9*b[(i+1)%4].
  - Timing is identical.
- When undefined: no inv_mode port; forward transform only, with no inverse logic synthesized.

Decomposition:
- Shared package aes_pkg:
  - GF_POLY=8'h1B, NUM_COLS=4.
  - typedef state_t (logic [127:0]), col_t (logic [31:0]).
  - enum mix_state_t {IDLE, BUSY, DONE}.
  - xtime function.
- One sub-module, mix_col_sub: combinational 32-bit forward column transform. Instantiated once and driven by a column mux.
- The inverse path, when enabled, reuses the existing inverse column unit on the same mux.

Test Plan:
- Reset, then data_in=128'hDB135345_F20A225C_01010101_C6C6C6C6 presented as columns 3..0 with in_valid=1 → in_ready drops next cycle; after 4 BUSY cycles out_valid=1 and data_out=128'h8E4DA1BC_9FDC589D_01010101_C6C6C6C6.
- Input 128'hD4D4D4D5_2D26314C_00000000_FFFFFFFF → data_out=128'hD5D5D7D6_4D7EBDF8_00000000_FFFFFFFF; check output latency is exactly 4 edges after acceptance.
- Backpressure: out_ready=0 for 10 cycles in DONE, with a new in_valid pulsed meanwhile → out_valid and data_out stay stable; the new input is not accepted until after the out handshake, then is processed normally.
- rst=1 during the second BUSY cycle → next cycle in_ready=1, out_valid=0, data_out=0; no out_valid pulse afterwards until a new input is accepted.
- Back-to-back: in_valid held high with two states and out_ready=1 → two outputs, the second accepted immediately after returning to IDLE, 6-cycle spacing.
- With MIX_COL_INV_EN: feed 128'h8E4DA1BC_9FDC589D_01010101_C6C6C6C6 with inv_mode=1 → data_out=128'hDB135345_F20A225C_01010101_C6C6C6C6.
